// File: rtl/dshot_frame_receiver_pkg.sv
// Shared DShot receiver definitions: frame size, FSM encodings and
// bit-period presets for a 48 MHz clock.
package dshot_frame_receiver_pkg;

    localparam int DSHOT_FRAME_BITS = 16;

    localparam logic [1:0] ST_RESYNC = 2'd0;
    localparam logic [1:0] ST_IDLE   = 2'd1;
    localparam logic [1:0] ST_HIGH   = 2'd2;
    localparam logic [1:0] ST_LOW    = 2'd3;

    localparam int CLKS_DSHOT150_48M = 320;
    localparam int CLKS_DSHOT300_48M = 160;
    localparam int CLKS_DSHOT600_48M = 80;

endpackage

// File: rtl/dshot_input_sync.sv
// Two-flop synchronizer for the raw DShot line with rise/fall pulses
// derived from the synchronized level.
module dshot_input_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic i_din,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= i_din;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_level = r_sync;
    assign o_rise  = r_sync & ~r_prev;
    assign o_fall  = ~r_sync & r_prev;

endmodule

// File: rtl/dshot_frame_receiver.sv
// DShot pulse-width bit classifier and 16-bit frame assembler with
// glitch, over-width and mid-frame timeout detection.
module dshot_frame_receiver
    import dshot_frame_receiver_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_DSHOT600_48M,
    parameter int ONE_THRESH   = 40,
    parameter int MIN_HIGH     = 10,
    parameter int MAX_HIGH     = 72,
    parameter int GAP_CLKS     = 160
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dshotIn,
    output logic [15:0] rawData,
    output logic        frameValid,
    output logic        frameError,
    output logic        busy
);

    localparam int WW = $clog2(GAP_CLKS + 1);
    localparam int LW = WW + 1;

    if (!(MIN_HIGH < ONE_THRESH && ONE_THRESH <= MAX_HIGH &&
          MAX_HIGH < CLKS_PER_BIT && CLKS_PER_BIT < GAP_CLKS)) begin : g_bad_params
        $error("dshot_frame_receiver: illegal timing parameters");
    end

    logic          w_level;
    logic          w_rise;
    logic          w_fall;
    logic [LW-1:0] w_len;
    logic          w_bit;
    logic          w_legal;
    logic          w_too_long;
    logic          w_gap;
    logic [15:0]   w_shifted;

    logic [1:0]    r_state;
    logic [WW-1:0] r_width;
    logic [4:0]    r_bitcnt;
    logic [14:0]   r_shreg;
    logic [15:0]   r_raw;
    logic          r_valid;
    logic          r_error;

    dshot_input_sync u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_din   (dshotIn),
        .o_level (w_level),
        .o_rise  (w_rise),
        .o_fall  (w_fall)
    );

    // The edge cycle itself belongs to the new level, so the counter
    // restarts at zero and w_len adds that cycle back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_width <= '0;
        end else if (w_rise || w_fall) begin
            r_width <= '0;
        end else if (r_width != WW'(GAP_CLKS)) begin
            r_width <= r_width + WW'(1);
        end
    end

    assign w_len      = {1'b0, r_width} + LW'(1);
    assign w_bit      = (w_len >= LW'(ONE_THRESH));
    assign w_legal    = (w_len >= LW'(MIN_HIGH)) && (w_len <= LW'(MAX_HIGH));
    assign w_too_long = w_level && (w_len > LW'(MAX_HIGH));
    assign w_gap      = !w_level && !w_fall && (w_len >= LW'(GAP_CLKS));
    assign w_shifted  = {r_shreg, w_bit};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_RESYNC;
            r_bitcnt <= '0;
            r_shreg  <= '0;
            r_raw    <= '0;
            r_valid  <= 1'b0;
            r_error  <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_error <= 1'b0;
            case (r_state)
                ST_RESYNC: begin
                    if (w_gap) r_state <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (w_rise) begin
                        r_state  <= ST_HIGH;
                        r_bitcnt <= '0;
                    end
                end
                ST_HIGH: begin
                    if (w_fall) begin
                        if (!w_legal) begin
                            r_error <= 1'b1;
                            r_state <= ST_RESYNC;
                        end else begin
                            r_shreg  <= w_shifted[14:0];
                            r_bitcnt <= r_bitcnt + 5'd1;
                            if (r_bitcnt == 5'(DSHOT_FRAME_BITS - 1)) begin
                                r_raw   <= w_shifted;
                                r_valid <= 1'b1;
                                r_state <= ST_RESYNC;
                            end else begin
                                r_state <= ST_LOW;
                            end
                        end
                    end else if (w_too_long) begin
                        r_error <= 1'b1;
                        r_state <= ST_RESYNC;
                    end
                end
                ST_LOW: begin
                    if (w_rise) begin
                        r_state <= ST_HIGH;
                    end else if (w_gap) begin
                        r_error <= 1'b1;
                        r_state <= ST_RESYNC;
                    end
                end
                default: r_state <= ST_RESYNC;
            endcase
        end
    end

    assign rawData    = r_raw;
    assign frameValid = r_valid;
    assign frameError = r_error;
    assign busy       = (r_state == ST_HIGH) || (r_state == ST_LOW);

endmodule

// File: tb/tb_dshot_frame_receiver.sv
// Randomized and directed bench for dshot_frame_receiver against a
// pulse-train level reference model.
module tb_dshot_frame_receiver;

    localparam int ONE_THRESH = 40;
    localparam int MIN_HIGH   = 10;
    localparam int MAX_HIGH   = 72;
    localparam int GAP        = 160;
    localparam int PERIOD     = 80;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        dshotIn = 1'b0;
    logic [15:0] rawData;
    logic        frameValid;
    logic        frameError;
    logic        busy;

    dshot_frame_receiver dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .dshotIn    (dshotIn),
        .rawData    (rawData),
        .frameValid (frameValid),
        .frameError (frameError),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int          n_valid = 0;
    int          n_err = 0;
    int          n_both = 0;
    int          n_long = 0;
    int          v_cyc = 0;
    int          e_cyc = 0;
    logic        pv = 1'b0;
    logic        pe = 1'b0;

    always @(negedge clk) begin
        if (frameValid) begin
            n_valid++;
            v_cyc = cyc;
        end
        if (frameError) begin
            n_err++;
            e_cyc = cyc;
        end
        if (frameValid && frameError) n_both++;
        if ((frameValid && pv) || (frameError && pe)) n_long++;
        pv = frameValid;
        pe = frameError;
    end

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model state: is the receiver armed for a new frame, and
    // the last good frame it should be presenting.
    bit          armed = 1'b0;
    logic [15:0] model_raw = '0;
    int          fall_cyc = 0;

    int tr_hi[16];
    int tr_lo[16];
    int tr_n = 0;

    task automatic pulse(input int h, input int l);
        dshotIn = 1'b1;
        repeat (h) @(negedge clk);
        dshotIn = 1'b0;
        fall_cyc = cyc;
        repeat (l) @(negedge clk);
    endtask

    task automatic build(input logic [15:0] d, input int h0, input int h1,
                         input int gap);
        for (int i = 0; i < 16; i++) begin
            tr_hi[i] = d[15-i] ? h1 : h0;
            tr_lo[i] = PERIOD - tr_hi[i];
        end
        tr_lo[15] = gap;
        tr_n = 16;
    endtask

    task automatic build_rand(input logic [15:0] d);
        for (int i = 0; i < 16; i++) begin
            if (d[15-i]) tr_hi[i] = $urandom_range(MAX_HIGH, ONE_THRESH);
            else tr_hi[i] = $urandom_range(ONE_THRESH - 1, MIN_HIGH);
            tr_lo[i] = PERIOD - tr_hi[i];
        end
        tr_lo[15] = 200;
        tr_n = 16;
    endtask

    task automatic run_train(input string tag);
        int          first_bad;
        logic [15:0] d;
        bit          exp_v;
        bit          exp_e;
        int          v0;
        int          e0;
        first_bad = 99;
        d = '0;
        for (int i = 0; i < tr_n; i++) begin
            if (first_bad == 99 &&
                (tr_hi[i] < MIN_HIGH || tr_hi[i] > MAX_HIGH))
                first_bad = i;
            d = {d[14:0], tr_hi[i] >= ONE_THRESH};
        end
        exp_v = armed && first_bad == 99 && tr_n == 16;
        exp_e = armed && (first_bad != 99 ||
                          (tr_n < 16 && tr_lo[tr_n-1] >= GAP));
        v0 = n_valid;
        e0 = n_err;
        for (int i = 0; i < tr_n; i++) begin
            pulse(tr_hi[i], tr_lo[i]);
            if (i == 8 && armed && first_bad > 8)
                check({tag, ".busy_mid"}, 32'(busy), 32'd1);
        end
        check({tag, ".valid_cnt"}, n_valid - v0, 32'(exp_v));
        check({tag, ".error_cnt"}, n_err - e0, 32'(exp_e));
        if (exp_v) begin
            model_raw = d;
            check({tag, ".latency"}, v_cyc - fall_cyc, 32'd3);
        end
        if (exp_e && first_bad == 99)
            check({tag, ".timeout_at"}, e_cyc - fall_cyc, GAP + 3);
        check({tag, ".rawData"}, 32'(rawData), 32'(model_raw));
        check({tag, ".busy_end"}, 32'(busy), 32'd0);
        armed = (tr_lo[tr_n-1] >= GAP);
    endtask

    initial begin
        int v0;
        int e0;
        logic [15:0] d;

        repeat (3) @(negedge clk);
        check("reset.rawData", 32'(rawData), 32'd0);
        check("reset.valid", 32'(frameValid), 32'd0);
        check("reset.error", 32'(frameError), 32'd0);
        check("reset.busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        repeat (200) @(negedge clk);
        armed = 1'b1;

        build(16'hA5C3, 30, 60, 200);
        run_train("t1_a5c3");

        build(16'h0000, 30, 60, 200);
        run_train("t2_0000");
        build(16'hFFFF, 30, 60, 200);
        run_train("t2_ffff");

        build(16'h3C96, 30, 60, 200);
        tr_n = 8;
        tr_lo[7] = 200;
        run_train("t3_timeout");

        build(16'h0F0F, 30, 60, 200);
        tr_hi[3] = 5;
        run_train("t4_glitch");
        build(16'hF0F0, 30, 60, 200);
        tr_hi[9] = 75;
        tr_lo[9] = 8;
        run_train("t4_wide");
        build(16'h1234, 30, 60, 200);
        run_train("t4_1234");

        for (int i = 0; i < 16; i++) begin
            tr_hi[i] = (i % 3 == 0) ? 39 : ((i % 3 == 1) ? 40 : 72);
            tr_lo[i] = PERIOD - tr_hi[i];
        end
        tr_lo[15] = 200;
        tr_n = 16;
        run_train("t5_bounds");
        tr_hi[5] = 73;
        tr_lo[5] = 8;
        run_train("t5_73");
        build(16'hBEEF, 30, 60, 100);
        run_train("t5_first");
        build(16'hCAFE, 30, 60, 200);
        run_train("t5_ignored");

        build(16'h5A5A, 30, 60, 200);
        v0 = n_valid;
        e0 = n_err;
        for (int i = 0; i < 10; i++) pulse(tr_hi[i], tr_lo[i]);
        dshotIn = 1'b1;
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        dshotIn = 1'b0;
        @(negedge clk);
        check("t6.rst_rawData", 32'(rawData), 32'd0);
        check("t6.rst_valid", 32'(frameValid), 32'd0);
        check("t6.rst_error", 32'(frameError), 32'd0);
        check("t6.rst_busy", 32'(busy), 32'd0);
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (200) @(negedge clk);
        check("t6.no_valid", n_valid - v0, 32'd0);
        check("t6.no_error", n_err - e0, 32'd0);
        model_raw = '0;
        armed = 1'b1;
        build(16'h6D2B, 30, 60, 200);
        run_train("t6_after");

        for (int k = 0; k < 16; k++) begin
            d = 16'($urandom);
            build_rand(d);
            if ($urandom_range(4, 0) == 0) begin
                int j;
                j = $urandom_range(15, 0);
                if ($urandom_range(1, 0) == 1) begin
                    tr_hi[j] = $urandom_range(MIN_HIGH - 1, 1);
                end else begin
                    tr_hi[j] = $urandom_range(90, MAX_HIGH + 1);
                    tr_lo[j] = (j == 15) ? tr_lo[j] : 8;
                end
            end
            if ($urandom_range(3, 0) == 0)
                tr_lo[15] = $urandom_range(150, 100);
            run_train($sformatf("rand%0d", k));
        end

        check("strobe_overlap", n_both, 32'd0);
        check("strobe_width", n_long, 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
